gate_sweep_ctrl: RTL and testbench

//  Self-test sequencer for a 2-input combinational gate (a, b -> c).
//  On start, drives a/b through 00,01,10,11 and waits a settle window.

---
 rtl/gate_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for a 2-input gate: sweeps {a,b} through 00..11, waits a
// settle window, samples c against EXPECTED and accumulates mismatches.
module gate_sweep_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECTED      = 4'b0111,
  parameter int         PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_c,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          vec, vec_nxt;
  logic [SET_W-1:0]    settle, settle_nxt;
  logic [PASS_W-1:0]   pass_cnt, pass_cnt_nxt;
  logic [7:0]          err_nxt;
  logic [3:0]          fail_nxt;
  logic                pass_nxt, busy_nxt, done_nxt, gate_a_nxt, gate_b_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      settle    <= '0;
      pass_cnt  <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      settle    <= settle_nxt;
      pass_cnt  <= pass_cnt_nxt;
      err_count <= err_nxt;
      fail_vec  <= fail_nxt;
      pass      <= pass_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      gate_a    <= gate_a_nxt;
      gate_b    <= gate_b_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    vec_nxt      = vec;
    settle_nxt   = settle;
    pass_cnt_nxt = pass_cnt;
    err_nxt      = err_count;
    fail_nxt     = fail_vec;
    pass_nxt     = pass;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt    = DRIVE;
          vec_nxt      = '0;
          settle_nxt   = '0;
          pass_cnt_nxt = '0;
          err_nxt      = '0;
          fail_nxt     = '0;
          pass_nxt     = 1'b0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_nxt = IDLE;
          pass_nxt  = 1'b0;
        end else if (settle == SETTLE_LAST) begin
          state_nxt  = SAMPLE;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle + 1'b1;
        end
      end
      SAMPLE: begin
        // An aborted sample leaves the partial results untouched.
        if (abort) begin
          state_nxt = IDLE;
          pass_nxt  = 1'b0;
        end else begin
          if (gate_c != EXPECTED[vec]) begin
            err_nxt       = sat_inc(err_count);
            fail_nxt[vec] = 1'b1;
          end
          if (vec != 2'd3) begin
            vec_nxt   = vec + 2'd1;
            state_nxt = DRIVE;
          end else if (pass_cnt != PASS_LAST) begin
            vec_nxt      = '0;
            pass_cnt_nxt = pass_cnt + 1'b1;
            state_nxt    = DRIVE;
          end else begin
            state_nxt = DONE;
            pass_nxt  = (err_nxt == 8'd0);
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_nxt   = (state_nxt == DRIVE) || (state_nxt == SAMPLE);
    done_nxt   = (state_nxt == DONE);
    gate_a_nxt = busy_nxt & vec_nxt[1];
    gate_b_nxt = busy_nxt & vec_nxt[0];
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: directed table and sequences plus random stimulus
// checked every cycle against a position-based reference model (two instances).
module tb_gate_sweep_ctrl;

  localparam int         S   = 2;
  localparam logic [3:0] EXP = 4'b0111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   mode [2];

  logic       ga0, gb0, busy0, done0, pass0, c0;
  logic [7:0] err0;
  logic [3:0] fail0;
  logic       ga1, gb1, busy1, done1, pass1, c1;
  logic [7:0] err1;
  logic [3:0] fail1;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  // Gate under test: 0 NAND, 1 AND, 2 stuck-at-1, 3 XOR
  function automatic logic gate_fn(input int m, input logic a, input logic b);
    case (m)
      0:       return ~(a & b);
      1:       return a & b;
      2:       return 1'b1;
      default: return a ^ b;
    endcase
  endfunction

  assign c0 = gate_fn(mode[0], ga0, gb0);
  assign c1 = gate_fn(mode[1], ga1, gb1);

  gate_sweep_ctrl #(.SETTLE_CYCLES(S), .EXPECTED(EXP), .PASSES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_c(c0),
    .gate_a(ga0), .gate_b(gb0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fail0));

  gate_sweep_ctrl #(.SETTLE_CYCLES(S), .EXPECTED(EXP), .PASSES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_c(c1),
    .gate_a(ga1), .gate_b(gb1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1));

  function automatic logic [16:0] pk(input logic a, input logic b, input logic bs,
                                     input logic dn, input logic ps,
                                     input logic [7:0] e, input logic [3:0] f);
    return {a, b, bs, dn, ps, e, f};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errs++;
      $display("FAIL %s @%0t: got a,b,busy,done,pass,err,fail=%h want %h", name, $time, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errs++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, expv);
    end
  endtask

  // Reference model: a run is a position counter; vector, sample instants and
  // completion follow arithmetically from the position.
  bit         m_active [2];
  bit         m_done   [2];
  int         m_pos    [2];
  logic       m_a [2], m_b [2], m_busy [2], m_pass [2];
  logic [7:0] m_err  [2];
  logic [3:0] m_fail [2];

  task automatic model_step(input int i, input int np);
    int L, n;
    logic [1:0] v;
    L = S + 1;
    n = 4 * np * L;
    if (m_active[i]) begin
      if (abort) begin
        m_active[i] = 0; m_busy[i] = 0; m_a[i] = 0; m_b[i] = 0; m_pass[i] = 0;
      end else begin
        if (m_pos[i] % L == L - 1) begin
          v = 2'((m_pos[i] / L) % 4);
          if (gate_fn(mode[i], v[1], v[0]) != EXP[v]) begin
            if (m_err[i] != 8'd255) m_err[i] = m_err[i] + 8'd1;
            m_fail[i][v] = 1'b1;
          end
        end
        m_pos[i]++;
        if (m_pos[i] == n) begin
          m_active[i] = 0; m_done[i] = 1; m_busy[i] = 0; m_a[i] = 0; m_b[i] = 0;
          m_pass[i] = (m_err[i] == 8'd0);
        end else begin
          v = 2'((m_pos[i] / L) % 4);
          m_a[i] = v[1]; m_b[i] = v[0]; m_busy[i] = 1;
        end
      end
    end else if (m_done[i]) begin
      m_done[i] = 0;
    end else if (start && !abort) begin
      m_active[i] = 1; m_pos[i] = 0; m_err[i] = 0; m_fail[i] = 0; m_pass[i] = 0;
      m_busy[i] = 1; m_a[i] = 0; m_b[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 0; m_done[i] = 0; m_pos[i] = 0; m_a[i] = 0; m_b[i] = 0;
        m_busy[i] = 0; m_pass[i] = 0; m_err[i] = 0; m_fail[i] = 0;
      end
    end else begin
      model_step(0, 1);
      model_step(1, 3);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_p1", pk(ga0, gb0, busy0, done0, pass0, err0, fail0),
            pk(m_a[0], m_b[0], m_busy[0], m_done[0], m_pass[0], m_err[0], m_fail[0]));
      check("model_p3", pk(ga1, gb1, busy1, done1, pass1, err1, fail1),
            pk(m_a[1], m_b[1], m_busy[1], m_done[1], m_pass[1], m_err[1], m_fail[1]));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy0 || busy1 || done0 || done1) && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) check_int("wait_idle_timeout", k, 0);
    step();
  endtask

  typedef struct {
    logic        start;
    logic [16:0] expv;
  } vec_t;

  vec_t tbl [14];

  initial begin : main
    int c_d0, c_d1, ndone;
    logic [16:0] at_d0, at_d1;

    // T1 sweep on a NAND gate, one record per clock edge
    tbl[0]  = '{1'b1, pk(0, 0, 1, 0, 0, 8'd0, 4'h0)};
    tbl[1]  = '{1'b0, pk(0, 0, 1, 0, 0, 8'd0, 4'h0)};
    tbl[2]  = '{1'b0, pk(0, 0, 1, 0, 0, 8'd0, 4'h0)};
    tbl[3]  = '{1'b0, pk(0, 1, 1, 0, 0, 8'd0, 4'h0)};
    tbl[4]  = '{1'b0, pk(0, 1, 1, 0, 0, 8'd0, 4'h0)};
    tbl[5]  = '{1'b0, pk(0, 1, 1, 0, 0, 8'd0, 4'h0)};
    tbl[6]  = '{1'b0, pk(1, 0, 1, 0, 0, 8'd0, 4'h0)};
    tbl[7]  = '{1'b0, pk(1, 0, 1, 0, 0, 8'd0, 4'h0)};
    tbl[8]  = '{1'b0, pk(1, 0, 1, 0, 0, 8'd0, 4'h0)};
    tbl[9]  = '{1'b0, pk(1, 1, 1, 0, 0, 8'd0, 4'h0)};
    tbl[10] = '{1'b0, pk(1, 1, 1, 0, 0, 8'd0, 4'h0)};
    tbl[11] = '{1'b0, pk(1, 1, 1, 0, 0, 8'd0, 4'h0)};
    tbl[12] = '{1'b0, pk(0, 0, 0, 1, 1, 8'd0, 4'h0)};
    tbl[13] = '{1'b0, pk(0, 0, 0, 0, 1, 8'd0, 4'h0)};

    mode[0] = 0; mode[1] = 0;
    step(); step(); step();
    check("reset_state", pk(ga0, gb0, busy0, done0, pass0, err0, fail0), '0);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start;
      step();
      check($sformatf("t1_vec%0d", i), pk(ga0, gb0, busy0, done0, pass0, err0, fail0), tbl[i].expv);
    end
    wait_idle();

    // T2 (AND gate, PASSES=1) and T3 (stuck-at-1, PASSES=3) in one run
    mode[0] = 1; mode[1] = 2;
    c_d0 = -1; c_d1 = -1; at_d0 = '0; at_d1 = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      step();
      if (done0 && c_d0 < 0) begin c_d0 = cyc; at_d0 = pk(0, 0, 0, 1, pass0, err0, fail0); end
      if (done1 && c_d1 < 0) begin c_d1 = cyc; at_d1 = pk(0, 0, 0, 1, pass1, err1, fail1); end
    end
    check_int("t2_done_cycle", c_d0, 12);
    check("t2_result", at_d0, pk(0, 0, 0, 1, 0, 8'd4, 4'hF));
    check_int("t3_done_cycle", c_d1, 36);
    check("t3_result", at_d1, pk(0, 0, 0, 1, 0, 8'd3, 4'h8));
    wait_idle();

    // T4 abort during the sample of vector 1; vector 0 already counted
    mode[0] = 1; mode[1] = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_after_abort", pk(ga0, gb0, busy0, done0, pass0, err0, fail0),
          pk(0, 0, 0, 0, 0, 8'd1, 4'h1));
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done0) ndone++;
    end
    check_int("t4_no_done", ndone, 0);
    check("t4_hold", pk(ga0, gb0, busy0, done0, pass0, err0, fail0),
          pk(0, 0, 0, 0, 0, 8'd1, 4'h1));
    wait_idle();

    // T5 start held through a run, then start+abort together in IDLE
    mode[0] = 0; mode[1] = 0;
    ndone = 0;
    start = 1'b1;
    step();
    for (int k = 1; k <= 13; k++) begin
      step();
      if (done0) ndone++;
    end
    check_int("t5_single_done", ndone, 1);
    check_int("t5_idle_after_done", int'(busy0), 0);
    step();
    check_int("t5_restart_first_idle", int'(busy0), 1);
    start = 1'b0;
    wait_idle();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_int("t5_abort_wins", int'(busy0), 0);
    step();
    check_int("t5_still_idle", int'(busy0 | done0), 0);
    wait_idle();

    // T6 reset mid-DRIVE, then a clean run
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("t6_reset_now", pk(ga0, gb0, busy0, done0, pass0, err0, fail0), '0);
    check("t6_reset_now_p3", pk(ga1, gb1, busy1, done1, pass1, err1, fail1), '0);
    step();
    rst_n = 1'b1;
    step();
    c_d0 = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (done0 && c_d0 < 0) begin c_d0 = cyc; at_d0 = pk(0, 0, 0, 1, pass0, err0, fail0); end
    end
    check_int("t6_done_cycle", c_d0, 12);
    check("t6_result", at_d0, pk(0, 0, 0, 1, 1, 8'd0, 4'h0));
    wait_idle();

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) mode[$urandom_range(0, 1)] = int'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    step(); step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
